// File: rtl/param_lfsr_shifter_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared constants for param_lfsr_shifter:
//   - MODE_* : 2-bit shift-mode encodings carried on the mode port.
//   - ST_*   : burst-engine FSM state encodings.
// Optional feature macro used elsewhere in the block: LFSR_LOCKUP_GUARD_EN.
// -----------------------------------------------------------------------------
package shift_pkg;

  localparam logic [1:0] MODE_SHR  = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_LFSR = 2'b10;
  localparam logic [1:0] MODE_ROR  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

endpackage

// File: rtl/param_lfsr_shifter_if.sv
// -----------------------------------------------------------------------------
// param_lfsr_shifter_if
// Control/data bundle between a requester (master) and param_lfsr_shifter
// (slave).
//   mode   [1:0]      shift mode, sampled on an accepted start
//   load              parallel-load request (idle only)
//   p_in   [WIDTH-1:0] parallel load data
//   start             burst request (idle only)
//   len    [LEN_W-1:0] number of shifts in the burst
//   sin               serial input, used live every shift cycle
//   sout              serial output
//   status [WIDTH-1:0] register contents
//   busy              burst in progress
//   done              one-cycle completion pulse
// -----------------------------------------------------------------------------
interface param_lfsr_shifter_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
);
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] p_in;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             sin;
  logic             sout;
  logic [WIDTH-1:0] status;
  logic             busy;
  logic             done;

  modport master (
    output mode, load, p_in, start, len, sin,
    input  sout, status, busy, done
  );

  modport slave (
    input  mode, load, p_in, start, len, sin,
    output sout, status, busy, done
  );
endinterface

// File: rtl/param_lfsr_shifter_step_logic.sv
// -----------------------------------------------------------------------------
// shift_step_logic
// Combinational next-register value for one shift step.
//   q_i    [WIDTH-1:0] current register value
//   mode_i [1:0]       latched shift mode
//   sin_i              serial input bit
//   q_o    [WIDTH-1:0] register value after one step
// Macro LFSR_LOCKUP_GUARD_EN: when defined, an LFSR step from the all-zero
// state reloads SEED so the generator cannot stay locked up.
// -----------------------------------------------------------------------------
module shift_step_logic
  import shift_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [1:0]       mode_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic             fb;
  logic [WIDTH-1:0] lfsr_nxt;

  assign fb = ^(q_i & TAPS);

`ifdef LFSR_LOCKUP_GUARD_EN
  assign lfsr_nxt = (q_i == '0) ? SEED : {fb, q_i[WIDTH-1:1]};
`else
  assign lfsr_nxt = {fb, q_i[WIDTH-1:1]};
`endif

  always_comb begin
    q_o = q_i;
    case (mode_i)
      MODE_SHR:  q_o = {sin_i, q_i[WIDTH-1:1]};
      MODE_SHL:  q_o = {q_i[WIDTH-2:0], sin_i};
      MODE_LFSR: q_o = lfsr_nxt;
      MODE_ROR:  q_o = {q_i[0], q_i[WIDTH-1:1]};
      default:   q_o = q_i;
    endcase
  end

endmodule

// File: rtl/param_lfsr_shifter.sv
// -----------------------------------------------------------------------------
// param_lfsr_shifter
// WIDTH-bit shift register with parallel load and four shift modes
// (SHR, SHL, Fibonacci LFSR, ROR), plus a start/len burst engine that runs
// len shifts autonomously and pulses done when finished.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    param_lfsr_shifter_if slave port (mode/load/p_in/start/len/sin in,
//          sout/status/busy/done out)
// Macro LFSR_LOCKUP_GUARD_EN (see shift_step_logic): all-zero LFSR recovery.
// -----------------------------------------------------------------------------
module param_lfsr_shifter
  import shift_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               LEN_W = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01)
) (
  input logic                  clk,
  input logic                  reset,
  param_lfsr_shifter_if.slave  bus
);

  logic [WIDTH-1:0] q_q,     q_d;
  logic [1:0]       mode_q,  mode_d;
  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] step_q;

  shift_step_logic #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_step (
    .q_i    (q_q),
    .mode_i (mode_q),
    .sin_i  (bus.sin),
    .q_o    (step_q)
  );

  always_comb begin
    q_d     = q_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // load wins over start; a coincident start is simply dropped
        if (bus.load) begin
          q_d = bus.p_in;
        end else if (bus.start) begin
          mode_d  = bus.mode;
          cnt_d   = bus.len;
          state_d = (bus.len == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        q_d   = step_q;
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q     <= SEED;
      mode_q  <= MODE_SHR;
      cnt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      q_q     <= q_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // SHL streams out of the MSB; every other mode streams out of the LSB
  assign bus.sout   = (mode_q == MODE_SHL) ? q_q[WIDTH-1] : q_q[0];
  assign bus.status = q_q;
  assign bus.busy   = (state_q == ST_SHIFT);
  assign bus.done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_param_lfsr_shifter.sv
module tb_param_lfsr_shifter;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  param_lfsr_shifter_if #(.WIDTH(8), .LEN_W(8)) b8 ();
  param_lfsr_shifter_if #(.WIDTH(4), .LEN_W(8)) b4 ();

  param_lfsr_shifter #(
    .WIDTH(8), .LEN_W(8), .TAPS(8'hB8), .SEED(8'h01)
  ) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8.slave)
  );

  param_lfsr_shifter #(
    .WIDTH(4), .LEN_W(8), .TAPS(4'b0011), .SEED(4'b0001)
  ) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b4.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] shr_tbl  [4]  = '{8'hA5, 8'hD2, 8'hE9, 8'hF4};
  logic       sout_tbl [3]  = '{1'b1, 1'b0, 1'b0};
  logic [3:0] lfsr_tbl [15] = '{4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b1100,
                                4'b0110, 4'b1011, 4'b0101, 4'b1010, 4'b1101,
                                4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [7:0] guard_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef LFSR_LOCKUP_GUARD_EN
    guard_exp = 8'h01;
`else
    guard_exp = 8'h00;
`endif
    b8.mode = 2'b00; b8.load = 1'b0; b8.p_in = '0; b8.start = 1'b0; b8.len = '0; b8.sin = 1'b0;
    b4.mode = 2'b00; b4.load = 1'b0; b4.p_in = '0; b4.start = 1'b0; b4.len = '0; b4.sin = 1'b0;

    // reset state
    #12;
    check("rst_status", 32'(b8.status), 32'h01);
    check("rst_busy",   32'(b8.busy),   32'h0);
    check("rst_done",   32'(b8.done),   32'h0);
    check("rst_sout",   32'(b8.sout),   32'h1);
    check("rst_status4", 32'(b4.status), 32'h1);
    tick;
    reset = 1'b1;
    tick;

    // load A5, SHR len=4 sin=1
    b8.load = 1'b1; b8.p_in = 8'hA5;
    tick;
    b8.load = 1'b0;
    check("load_a5", 32'(b8.status), 32'hA5);
    b8.start = 1'b1; b8.mode = 2'b00; b8.len = 8'd4; b8.sin = 1'b1;
    tick;
    b8.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("shr_busy",   32'(b8.busy),   32'h1);
      check("shr_done0",  32'(b8.done),   32'h0);
      check("shr_status", 32'(b8.status), 32'(shr_tbl[i]));
      tick;
    end
    check("shr_final", 32'(b8.status), 32'hFA);
    check("shr_done",  32'(b8.done),   32'h1);
    check("shr_idle",  32'(b8.busy),   32'h0);
    tick;
    check("shr_done_once", 32'(b8.done), 32'h0);

    // SHL len=3 from 81 sin=0, then ROR len=8
    b8.load = 1'b1; b8.p_in = 8'h81; b8.sin = 1'b0;
    tick;
    b8.load = 1'b0;
    b8.start = 1'b1; b8.mode = 2'b01; b8.len = 8'd3;
    tick;
    b8.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("shl_sout", 32'(b8.sout), 32'(sout_tbl[i]));
      tick;
    end
    check("shl_final", 32'(b8.status), 32'h08);
    check("shl_done",  32'(b8.done),   32'h1);
    tick;
    b8.start = 1'b1; b8.mode = 2'b11; b8.len = 8'd8;
    tick;
    b8.start = 1'b0;
    check("ror_mid", 32'(b8.status), 32'h08);
    repeat (8) tick;
    check("ror_final", 32'(b8.status), 32'h08);
    check("ror_done",  32'(b8.done),   32'h1);
    tick;

    // 4-bit maximal LFSR walks all 15 nonzero states
    b4.start = 1'b1; b4.mode = 2'b10; b4.len = 8'd15;
    tick;
    b4.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick;
      check("lfsr4_step", 32'(b4.status), 32'(lfsr_tbl[i]));
    end
    check("lfsr4_done", 32'(b4.done), 32'h1);
    tick;

    // start + load together: load only
    b8.load = 1'b1; b8.start = 1'b1; b8.p_in = 8'h3C; b8.mode = 2'b00; b8.len = 8'd5;
    tick;
    b8.load = 1'b0; b8.start = 1'b0;
    check("sl_status", 32'(b8.status), 32'h3C);
    check("sl_busy",   32'(b8.busy),   32'h0);
    tick;
    check("sl_nodone", 32'(b8.done),   32'h0);
    check("sl_hold",   32'(b8.status), 32'h3C);

    // len = 0: straight to done
    b8.start = 1'b1; b8.len = 8'd0;
    tick;
    b8.start = 1'b0;
    check("len0_busy",   32'(b8.busy),   32'h0);
    check("len0_done",   32'(b8.done),   32'h1);
    check("len0_status", 32'(b8.status), 32'h3C);
    tick;
    check("len0_done_clr", 32'(b8.done), 32'h0);

    // start/load during busy are ignored
    b8.start = 1'b1; b8.mode = 2'b11; b8.len = 8'd2;
    tick;
    b8.start = 1'b1; b8.load = 1'b1; b8.p_in = 8'hFF; b8.mode = 2'b00; b8.len = 8'd9; b8.sin = 1'b1;
    check("busy_ign_busy", 32'(b8.busy), 32'h1);
    tick;
    b8.start = 1'b0; b8.load = 1'b0;
    check("busy_ign_mid", 32'(b8.status), 32'h1E);
    tick;
    check("busy_ign_done",   32'(b8.done),   32'h1);
    check("busy_ign_status", 32'(b8.status), 32'h0F);
    tick;
    check("busy_ign_idle", 32'(b8.busy), 32'h0);
    tick;
    check("busy_ign_noq",  32'(b8.busy),   32'h0);
    check("busy_ign_keep", 32'(b8.status), 32'h0F);

    // LFSR step from all-zero
    b8.load = 1'b1; b8.p_in = 8'h00;
    tick;
    b8.load = 1'b0;
    b8.start = 1'b1; b8.mode = 2'b10; b8.len = 8'd1;
    tick;
    b8.start = 1'b0;
    tick;
    check("lfsr_zero", 32'(b8.status), 32'(guard_exp));
    check("lfsr_zero_done", 32'(b8.done), 32'h1);
    tick;

    // async reset mid-burst
    b8.load = 1'b1; b8.p_in = 8'hC3;
    tick;
    b8.load = 1'b0;
    b8.start = 1'b1; b8.mode = 2'b00; b8.len = 8'd10; b8.sin = 1'b0;
    tick;
    b8.start = 1'b0;
    tick;
    tick;
    check("arst_pre_busy", 32'(b8.busy), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_status", 32'(b8.status), 32'h01);
    check("arst_busy",   32'(b8.busy),   32'h0);
    check("arst_done",   32'(b8.done),   32'h0);
    tick;
    check("arst_hold_done", 32'(b8.done), 32'h0);
    reset = 1'b1;
    tick;
    check("arst_after_busy",   32'(b8.busy),   32'h0);
    check("arst_after_done",   32'(b8.done),   32'h0);
    check("arst_after_status", 32'(b8.status), 32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
